trace_capture_ctrl: RTL and testbench

Capture sequencer for the trace datapath, in the trace_clk domain between the USB register block and the trace event FIFO.
- Arming: arms capture on a host request.
- Start: waits for the selected trigger source (immediate, target pin, or pattern-match hit).
- Gating: gates FIFO writes while capturing.
- Stop: ends capture on event limit, FIFO overflow, or abort.
- Trigger output: drives a fixed-width trigger pulse to the CW trigger output.

---
 rtl/trace_capture_ctrl.sv | 118 +++++++++++
 tb/tb_trace_capture_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture_ctrl.sv
// Capture sequencer for the trace datapath: arm, wait for a trigger, gate FIFO
// writes during capture, and stop on event limit, FIFO overflow or abort.
module trace_capture_ctrl #(
  parameter int pCNT_WIDTH  = 16,
  parameter int pTRIG_PULSE = 8
) (
  input  logic                  trace_clk,
  input  logic                  reset_n,
  input  logic                  I_arm,
  input  logic                  I_abort,
  input  logic [1:0]            I_trig_mode,
  input  logic                  I_m3_trig,
  input  logic                  I_match_hit,
  input  logic [pCNT_WIDTH-1:0] I_max_events,
  input  logic                  I_event_valid,
  input  logic                  I_fifo_full,
  output logic                  O_fifo_wr,
  output logic                  O_armed,
  output logic                  O_capturing,
  output logic                  O_done,
  output logic                  O_overflow,
  output logic [pCNT_WIDTH-1:0] O_event_count,
  output logic                  O_trig_out,
  output logic [1:0]            O_dbg_state
);

  localparam int PW = $clog2(pTRIG_PULSE + 1);
  localparam logic [PW-1:0] PULSE_LOAD = PW'(pTRIG_PULSE);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  // Handshake: O_fifo_wr is a single-cycle write strobe; the FIFO accepts the
  // event whenever the strobe is high, which is only possible when not full.
  state_t                state_q, state_next;
  logic [pCNT_WIDTH-1:0] count_q, count_next, count_inc;
  logic                  overflow_q, overflow_next;
  logic                  m3_prev_q, m3_prev_next;
  logic [PW-1:0]         pulse_q, pulse_next;
  logic                  m3_edge, trig_hit;

  assign O_armed       = (state_q == S_ARMED);
  assign O_capturing   = (state_q == S_CAPTURE);
  assign O_done        = (state_q == S_DONE);
  assign O_overflow    = overflow_q;
  assign O_event_count = count_q;
  assign O_trig_out    = (pulse_q != '0);
  assign O_dbg_state   = state_q;
  assign O_fifo_wr     = I_event_valid & O_capturing & ~I_fifo_full;

  assign count_inc = (&count_q) ? count_q : count_q + 1'b1;
  assign m3_edge   = I_m3_trig & ~m3_prev_q;

  always_comb begin
    trig_hit = 1'b0;
    case (I_trig_mode)
      2'd0:    trig_hit = 1'b1;
      2'd1:    trig_hit = m3_edge;
      2'd2:    trig_hit = I_match_hit;
      default: trig_hit = m3_edge | I_match_hit;
    endcase
  end

  always_comb begin
    state_next    = state_q;
    count_next    = count_q;
    overflow_next = overflow_q;
    m3_prev_next  = m3_prev_q;
    pulse_next    = (pulse_q != '0) ? pulse_q - 1'b1 : pulse_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (I_arm) begin
          state_next    = S_ARMED;
          count_next    = '0;
          overflow_next = 1'b0;
          m3_prev_next  = I_m3_trig;
        end
      end
      S_ARMED: begin
        m3_prev_next = I_m3_trig;
        if (I_abort) begin
          state_next = S_DONE;
        end else if (trig_hit) begin
          state_next = S_CAPTURE;
          // A pulse already in flight runs to completion and is not restarted.
          if (pulse_q == '0) pulse_next = PULSE_LOAD;
        end
      end
      S_CAPTURE: begin
        if (O_fifo_wr) count_next = count_inc;
        if (I_abort) state_next = S_DONE;
        if (O_fifo_wr && (I_max_events != '0) && (count_inc == I_max_events))
          state_next = S_DONE;
        if (I_event_valid && I_fifo_full) begin
          overflow_next = 1'b1;
          state_next    = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge trace_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      overflow_q <= 1'b0;
      m3_prev_q  <= 1'b0;
      pulse_q    <= '0;
    end else begin
      state_q    <= state_next;
      count_q    <= count_next;
      overflow_q <= overflow_next;
      m3_prev_q  <= m3_prev_next;
      pulse_q    <= pulse_next;
    end
  end

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Bench for trace_capture_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a phase-level model.
module tb_trace_capture_ctrl;

  localparam int P_PULSE = 8;
  localparam int PH_IDLE = 0, PH_ARMED = 1, PH_CAP = 2, PH_DONE = 3;

  logic        trace_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        I_arm = 1'b0, I_abort = 1'b0, I_m3_trig = 1'b0, I_match_hit = 1'b0;
  logic [1:0]  I_trig_mode = 2'd0;
  logic [15:0] I_max_events = '0;
  logic        I_event_valid = 1'b0, I_fifo_full = 1'b0;

  logic        O_fifo_wr, O_armed, O_capturing, O_done, O_overflow, O_trig_out;
  logic [15:0] O_event_count;
  logic [1:0]  O_dbg_state;

  logic        s_fifo_wr, s_armed, s_capturing, s_done, s_overflow, s_trig_out;
  logic [3:0]  s_event_count;
  logic [1:0]  s_dbg_state;

  int checks = 0, failures = 0;
  int wr_seen = 0, trig_seen = 0, cap_seen = 0, arm_seen = 0;

  // Model state, written only by model_loop.
  int m_phase = PH_IDLE, m_cnt = 0, m_pulse = 0;
  bit m_ovf = 0, m_prev = 0;

  always #5 trace_clk = ~trace_clk;

  trace_capture_ctrl #(.pCNT_WIDTH(16), .pTRIG_PULSE(P_PULSE)) dut (
    .trace_clk(trace_clk), .reset_n(reset_n), .I_arm(I_arm), .I_abort(I_abort),
    .I_trig_mode(I_trig_mode), .I_m3_trig(I_m3_trig), .I_match_hit(I_match_hit),
    .I_max_events(I_max_events), .I_event_valid(I_event_valid), .I_fifo_full(I_fifo_full),
    .O_fifo_wr(O_fifo_wr), .O_armed(O_armed), .O_capturing(O_capturing), .O_done(O_done),
    .O_overflow(O_overflow), .O_event_count(O_event_count), .O_trig_out(O_trig_out),
    .O_dbg_state(O_dbg_state)
  );

  trace_capture_ctrl #(.pCNT_WIDTH(4), .pTRIG_PULSE(P_PULSE)) dut4 (
    .trace_clk(trace_clk), .reset_n(reset_n), .I_arm(I_arm), .I_abort(I_abort),
    .I_trig_mode(I_trig_mode), .I_m3_trig(I_m3_trig), .I_match_hit(I_match_hit),
    .I_max_events(I_max_events[3:0]), .I_event_valid(I_event_valid), .I_fifo_full(I_fifo_full),
    .O_fifo_wr(s_fifo_wr), .O_armed(s_armed), .O_capturing(s_capturing), .O_done(s_done),
    .O_overflow(s_overflow), .O_event_count(s_event_count), .O_trig_out(s_trig_out),
    .O_dbg_state(s_dbg_state)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge trace_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Cycle model: what the sequencer must do this edge, from its stated rules.
  task automatic model_loop();
    forever begin
      @(posedge trace_clk);
      if (!reset_n) begin
        m_phase = PH_IDLE; m_cnt = 0; m_pulse = 0; m_ovf = 0; m_prev = 0;
      end else begin
        int  nxt;
        bit  fired, edge_m3, wrote;
        nxt     = m_phase;
        fired   = 0;
        edge_m3 = I_m3_trig && !m_prev;
        wrote   = (m_phase == PH_CAP) && I_event_valid && !I_fifo_full;
        if (m_phase == PH_IDLE || m_phase == PH_DONE) begin
          if (I_arm) begin
            nxt = PH_ARMED; m_cnt = 0; m_ovf = 0; m_prev = I_m3_trig;
          end
        end else if (m_phase == PH_ARMED) begin
          if (I_abort) nxt = PH_DONE;
          else begin
            fired = (I_trig_mode == 0) ||
                    ((I_trig_mode == 1 || I_trig_mode == 3) && edge_m3) ||
                    ((I_trig_mode == 2 || I_trig_mode == 3) && I_match_hit);
            if (fired) nxt = PH_CAP;
          end
          m_prev = I_m3_trig;
        end else begin
          if (I_abort) nxt = PH_DONE;
          if (wrote) begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (I_max_events != 0 && m_cnt == int'(I_max_events)) nxt = PH_DONE;
          end
          if (I_event_valid && I_fifo_full) begin
            m_ovf = 1; nxt = PH_DONE;
          end
        end
        if (fired && m_pulse == 0) m_pulse = P_PULSE;
        else if (m_pulse > 0) m_pulse = m_pulse - 1;
        m_phase = nxt;
      end
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge trace_clk);
      if (!reset_n) begin
        check("rst_armed", O_armed, 0);
        check("rst_capturing", O_capturing, 0);
        check("rst_done", O_done, 0);
        check("rst_overflow", O_overflow, 0);
        check("rst_count", O_event_count, 0);
        check("rst_trig", O_trig_out, 0);
        check("rst_fifo_wr", O_fifo_wr, 0);
      end else begin
        check("fifo_wr", O_fifo_wr,
              int'((m_phase == PH_CAP) && I_event_valid && !I_fifo_full));
        check("armed", O_armed, int'(m_phase == PH_ARMED));
        check("capturing", O_capturing, int'(m_phase == PH_CAP));
        check("done", O_done, int'(m_phase == PH_DONE));
        check("overflow", O_overflow, int'(m_ovf));
        check("count", O_event_count, m_cnt);
        check("trig_out", O_trig_out, int'(m_pulse > 0));
      end
      if (O_fifo_wr) wr_seen++;
      if (O_trig_out) trig_seen++;
      if (O_capturing) cap_seen++;
      if (O_armed) arm_seen++;
    end
  endtask

  initial begin
    int wr0, trig0, cap0, arm0;
    fork
      model_loop();
      compare_loop();
    join_none

    // Clock/reset
    idle(3);
    reset_n = 1'b1;
    idle(2);

    // Async reset in the middle of a capture
    I_trig_mode = 2'd0; I_max_events = 16'd0; I_event_valid = 1'b1;
    I_arm = 1'b1; tick(); I_arm = 1'b0;
    idle(4);
    check("pre_reset_capturing", O_capturing, 1);
    @(negedge trace_clk); #2;
    reset_n = 1'b0;
    #1;
    check("async_capturing", O_capturing, 0);
    check("async_count", O_event_count, 0);
    check("async_trig", O_trig_out, 0);
    check("async_fifo_wr", O_fifo_wr, 0);
    idle(2);
    reset_n = 1'b1;
    idle(2);

    // Immediate trigger, limit of 5 events
    wr0 = wr_seen; trig0 = trig_seen; arm0 = arm_seen;
    I_max_events = 16'd5;
    I_arm = 1'b1; tick(); I_arm = 1'b0;
    idle(14);
    check("imm_writes", wr_seen - wr0, 5);
    check("imm_count", O_event_count, 5);
    check("imm_done", O_done, 1);
    check("imm_trig_len", trig_seen - trig0, 8);
    check("imm_armed_cycles", arm_seen - arm0, 1);

    // m3 edge trigger with the pin already high at arm time
    I_event_valid = 1'b0; I_trig_mode = 2'd1; I_m3_trig = 1'b1;
    I_arm = 1'b1; tick(); I_arm = 1'b0;
    idle(4);
    check("m3_high_stays_armed", O_armed, 1);
    I_m3_trig = 1'b0; tick();
    check("m3_low_armed", O_armed, 1);
    I_m3_trig = 1'b1; tick();
    check("m3_edge_capturing", O_capturing, 1);
    I_abort = 1'b1; tick(); I_abort = 1'b0;
    idle(10);

    // Match hit racing abort
    cap0 = cap_seen; trig0 = trig_seen;
    I_trig_mode = 2'd2;
    I_arm = 1'b1; tick(); I_arm = 1'b0;
    I_match_hit = 1'b1; I_abort = 1'b1; tick();
    I_match_hit = 1'b0; I_abort = 1'b0;
    idle(3);
    check("race_done", O_done, 1);
    check("race_cap_cycles", cap_seen - cap0, 0);
    check("race_trig_cycles", trig_seen - trig0, 0);

    // Overflow after three writes in unlimited mode
    wr0 = wr_seen;
    I_trig_mode = 2'd0; I_max_events = 16'd0;
    I_arm = 1'b1; tick(); I_arm = 1'b0;
    I_event_valid = 1'b1; tick();
    idle(3);
    I_fifo_full = 1'b1; tick();
    idle(2);
    check("ovf_count", O_event_count, 3);
    check("ovf_flag", O_overflow, 1);
    check("ovf_done", O_done, 1);
    check("ovf_writes", wr_seen - wr0, 3);

    // Re-arm clears status; arm during capture is ignored
    I_fifo_full = 1'b0; I_event_valid = 1'b0;
    I_arm = 1'b1; tick(); I_arm = 1'b0;
    check("rearm_count", O_event_count, 0);
    check("rearm_overflow", O_overflow, 0);
    check("rearm_done", O_done, 0);
    check("rearm_armed", O_armed, 1);
    I_event_valid = 1'b1; tick();
    tick();
    I_arm = 1'b1; tick(); I_arm = 1'b0;
    tick();
    check("arm_in_capture_count", O_event_count, 3);
    check("arm_in_capture_state", O_capturing, 1);
    I_abort = 1'b1; tick(); I_abort = 1'b0; I_event_valid = 1'b0;
    idle(10);

    // Gapped valid with a limit of 4
    cap0 = cap_seen; wr0 = wr_seen;
    I_max_events = 16'd4;
    I_arm = 1'b1; tick(); I_arm = 1'b0;
    tick();
    for (int k = 0; k < 10; k++) begin
      I_event_valid = (k % 2 == 0);
      tick();
    end
    I_event_valid = 1'b0;
    idle(2);
    check("gap_cap_cycles", cap_seen - cap0, 7);
    check("gap_writes", wr_seen - wr0, 4);
    check("gap_count", O_event_count, 4);
    check("gap_done", O_done, 1);

    // Saturation of a 4-bit counter over 20 events
    I_max_events = 16'd0;
    I_arm = 1'b1; tick(); I_arm = 1'b0;
    I_event_valid = 1'b1; tick();
    idle(20);
    check("sat4_count", s_event_count, 15);
    check("sat4_capturing", s_capturing, 1);
    check("sat16_count", O_event_count, 20);
    I_abort = 1'b1; tick(); I_abort = 1'b0;
    idle(10);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      I_arm         = ($urandom_range(0, 9) == 0);
      I_abort       = ($urandom_range(0, 39) == 0);
      I_match_hit   = ($urandom_range(0, 7) == 0);
      I_event_valid = ($urandom_range(0, 9) < 7);
      I_fifo_full   = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) I_m3_trig = ~I_m3_trig;
      if ($urandom_range(0, 19) == 0) I_trig_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) I_max_events = 16'($urandom_range(0, 6));
      tick();
    end
    I_arm = 1'b0; I_abort = 1'b0; I_match_hit = 1'b0;
    I_event_valid = 1'b0; I_fifo_full = 1'b0;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
